bsg_cache_multi_req_arbiter: RTL and testbench

BSG_CACHE_MULTI_REQ_ARBITER -- requirements
Module: bsg_cache_multi_req_arbiter

---
 rtl/bsg_cache_multi_req_arbiter.sv | 153 +++++++++++++++
 tb/tb_bsg_cache_multi_req_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_cache_multi_req_arbiter.sv
// bsg_cache_multi_req_arbiter
//
// Shares one cache port among num_req_p requester channels.
// Requests are granted round-robin. A tag FIFO records which channel owns
// each in-flight request. Cache responses come back in order, so each one
// is steered to the channel at the FIFO head. Both paths are combinational,
// so the arbiter adds no latency.
//
// Ports
//   clk_i, reset_i   : clock, synchronous active-high reset
//   req_pkt_i        : per-channel packets, channel i in slice i
//   req_v_i          : per-channel request valid
//   req_yumi_o       : per-channel request accepted (granted channel only)
//   resp_data_o      : per-channel response data (head channel slice only)
//   resp_v_o         : per-channel response valid
//   resp_ready_i     : per-channel response ready
//   cache_pkt_o      : granted packet to the cache
//   cache_v_o        : packet valid to the cache
//   cache_yumi_i     : cache accepted the packet
//   cache_data_i     : cache response data
//   cache_v_i        : cache response valid
//   cache_yumi_o     : cache response consumed
//   outstanding_o    : number of in-flight requests (0..max_out_p)
module bsg_cache_multi_req_arbiter #(
    parameter int num_req_p    = 4,
    parameter int addr_width_p = 32,
    parameter int data_width_p = 32,
    // opcode + address + data + byte mask
    parameter int pkt_width_p  = 6 + addr_width_p + data_width_p + data_width_p / 8,
    parameter int max_out_p    = 8
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic [num_req_p*pkt_width_p-1:0]     req_pkt_i,
    input  logic [num_req_p-1:0]                 req_v_i,
    output logic [num_req_p-1:0]                 req_yumi_o,
    output logic [num_req_p*data_width_p-1:0]    resp_data_o,
    output logic [num_req_p-1:0]                 resp_v_o,
    input  logic [num_req_p-1:0]                 resp_ready_i,
    output logic [pkt_width_p-1:0]               cache_pkt_o,
    output logic                                 cache_v_o,
    input  logic                                 cache_yumi_i,
    input  logic [data_width_p-1:0]              cache_data_i,
    input  logic                                 cache_v_i,
    output logic                                 cache_yumi_o,
    output logic [$clog2(max_out_p+1)-1:0]       outstanding_o
);

    localparam int tag_w_lp = $clog2(num_req_p);
    localparam int ptr_w_lp = $clog2(max_out_p);
    localparam int cnt_w_lp = $clog2(max_out_p + 1);

    logic [tag_w_lp-1:0] rr_ptr_r, rr_ptr_next;
    logic [ptr_w_lp-1:0] wr_ptr_r, rd_ptr_r;
    logic [cnt_w_lp-1:0] count_r, count_next;
    logic [tag_w_lp-1:0] tag_mem [max_out_p];

    logic [pkt_width_p-1:0] req_pkt_arr [num_req_p];
    logic [tag_w_lp-1:0]    grant_idx;
    logic [tag_w_lp-1:0]    cand;
    logic [tag_w_lp-1:0]    head_tag;
    logic                   any_req;
    logic                   tag_full, tag_empty;
    logic                   push, pop;
    logic                   route_ok, resp_valid;

    assign tag_full  = (count_r == cnt_w_lp'(max_out_p));
    assign tag_empty = (count_r == '0);
    assign head_tag  = tag_mem[rd_ptr_r];

    // Round-robin search: walk backwards from the last candidate so the
    // first requester at or after rr_ptr_r overwrites all later ones.
    always_comb begin
        grant_idx = '0;
        cand      = '0;
        for (int k = num_req_p - 1; k >= 0; k--) begin
            cand = tag_w_lp'((int'(rr_ptr_r) + k) % num_req_p);
            if (req_v_i[cand]) begin
                grant_idx = cand;
            end
        end
    end

    assign rr_ptr_next = (grant_idx == tag_w_lp'(num_req_p - 1)) ? '0 : grant_idx + 1'b1;

    assign any_req     = |req_v_i;
    // A pop in the same cycle does not lift the full condition; the freed
    // slot becomes usable on the following cycle.
    assign cache_v_o   = ~reset_i & any_req & ~tag_full;
    assign cache_pkt_o = req_pkt_arr[grant_idx];
    assign push        = cache_v_o & cache_yumi_i;

    assign route_ok     = ~reset_i & ~tag_empty;
    assign resp_valid   = route_ok & cache_v_i;
    assign cache_yumi_o = resp_valid & resp_ready_i[head_tag];
    assign pop          = cache_yumi_o;

    genvar gi;
    generate
        for (gi = 0; gi < num_req_p; gi++) begin : g_chan
            assign req_pkt_arr[gi] = req_pkt_i[gi*pkt_width_p +: pkt_width_p];
            assign req_yumi_o[gi]  = push & (grant_idx == tag_w_lp'(gi));
            assign resp_v_o[gi]    = resp_valid & (head_tag == tag_w_lp'(gi));
            assign resp_data_o[gi*data_width_p +: data_width_p] =
                (route_ok && (head_tag == tag_w_lp'(gi))) ? cache_data_i : '0;
        end
    endgenerate

    always_comb begin
        count_next = count_r;
        if (push && !pop) begin
            count_next = count_r + 1'b1;
        end else if (pop && !push) begin
            count_next = count_r - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            tag_mem[wr_ptr_r] <= grant_idx;
        end
    end

    // Pointers wrap naturally since max_out_p is a power of two.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_ptr_r <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
                rr_ptr_r <= rr_ptr_next;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            count_r <= count_next;
        end
    end

    assign outstanding_o = count_r;

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i && cache_v_i && tag_empty) begin
            $error("bsg_cache_multi_req_arbiter: cache response with no outstanding request");
        end
    end
`endif

endmodule

// File: tb/tb_bsg_cache_multi_req_arbiter.sv
module tb_bsg_cache_multi_req_arbiter;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int PW = 6 + AW + DW + DW / 8;
    localparam int MO = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NR*PW-1:0]     req_pkt;
    logic [NR-1:0]        req_v;
    logic [NR-1:0]        req_yumi;
    logic [NR*DW-1:0]     resp_data;
    logic [NR-1:0]        resp_v;
    logic [NR-1:0]        resp_ready;
    logic [PW-1:0]        c_pkt;
    logic                 c_v_out;
    logic                 c_yumi_in;
    logic [DW-1:0]        c_data;
    logic                 c_v_in;
    logic                 c_yumi_out;
    logic [3:0]           outstanding;

    int checks = 0;
    int errors = 0;

    // Reference model: list of owning channels in issue order, plus pointer.
    int q[$];
    int rr_m;
    int m_g;
    logic m_push, m_pop;

    typedef struct {
        logic [3:0] rv;
        logic       cy;
        logic [3:0] exp_yumi;
        logic       exp_cv;
        int         exp_out;
    } vec_t;
    vec_t tbl[10];

    always #5 clk = ~clk;

    bsg_cache_multi_req_arbiter #(
        .num_req_p   (NR),
        .addr_width_p(AW),
        .data_width_p(DW),
        .pkt_width_p (PW),
        .max_out_p   (MO)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .req_pkt_i    (req_pkt),
        .req_v_i      (req_v),
        .req_yumi_o   (req_yumi),
        .resp_data_o  (resp_data),
        .resp_v_o     (resp_v),
        .resp_ready_i (resp_ready),
        .cache_pkt_o  (c_pkt),
        .cache_v_o    (c_v_out),
        .cache_yumi_i (c_yumi_in),
        .cache_data_i (c_data),
        .cache_v_i    (c_v_in),
        .cache_yumi_o (c_yumi_out),
        .outstanding_o(outstanding)
    );

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] rv, input logic cy, input logic cv,
                         input logic [31:0] cd, input logic [3:0] rr);
        logic [95:0] r;
        req_v = rv; c_yumi_in = cy; c_v_in = cv; c_data = cd; resp_ready = rr;
        for (int c = 0; c < NR; c++) begin
            r = {$urandom, $urandom, $urandom};
            req_pkt[c*PW +: PW] = r[PW-1:0];
        end
    endtask

    // Let combinational outputs settle, then compare against the model.
    task automatic settle();
        logic [3:0]   e_yumi, e_rv;
        logic         e_cv, e_cy;
        logic [127:0] e_rd;
        int           h;
        #1;
        e_yumi = '0; e_rv = '0; e_cv = 1'b0; e_cy = 1'b0; e_rd = '0;
        m_push = 1'b0; m_pop = 1'b0; m_g = 0;
        if (!reset) begin
            e_cv = (req_v != 0) && (q.size() < MO);
            if (e_cv) begin
                for (int k = 0; k < NR; k++) begin
                    if (req_v[2'((rr_m + k) % NR)]) begin
                        m_g = (rr_m + k) % NR;
                        break;
                    end
                end
                m_push = c_yumi_in;
                e_yumi[2'(m_g)] = m_push;
            end
            if (q.size() > 0) begin
                h = q[0];
                e_rd[h*DW +: DW] = c_data;
                if (c_v_in) begin
                    e_rv[2'(h)] = 1'b1;
                    m_pop = resp_ready[2'(h)];
                    e_cy = m_pop;
                end
            end
        end
        chk("cache_v_o", c_v_out, e_cv);
        chk("req_yumi_o", req_yumi, e_yumi);
        if (e_cv) chk("cache_pkt_o", c_pkt, req_pkt[m_g*PW +: PW]);
        chk("resp_v_o", resp_v, e_rv);
        chk("cache_yumi_o", c_yumi_out, e_cy);
        if (!reset && q.size() > 0) chk("resp_data_o", resp_data, e_rd);
        chk("outstanding_o", outstanding, q.size());
    endtask

    task automatic commit();
        @(posedge clk);
        if (reset) begin
            q.delete();
            rr_m = 0;
        end else begin
            if (m_pop) begin
                $display("resp  ch%0d data=%0h", q[0], c_data);
                void'(q.pop_front());
            end
            if (m_push) begin
                $display("req   ch%0d accepted", m_g);
                q.push_back(m_g);
                rr_m = (m_g + 1) % NR;
            end
        end
        #1;
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && q.size() > 0; n++) begin
            drive(4'h0, 1'b0, 1'b1, $urandom, 4'hF);
            settle();
            commit();
        end
        drive(4'h0, 1'b0, 1'b0, 32'h0, 4'hF);
        settle();
        chk("drain_outstanding", outstanding, 0);
        commit();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // All channels request, cache always accepts until full.
        tbl[0] = '{4'hF, 1'b1, 4'h1, 1'b1, 0};
        tbl[1] = '{4'hF, 1'b1, 4'h2, 1'b1, 1};
        tbl[2] = '{4'hF, 1'b1, 4'h4, 1'b1, 2};
        tbl[3] = '{4'hF, 1'b1, 4'h8, 1'b1, 3};
        tbl[4] = '{4'hF, 1'b1, 4'h1, 1'b1, 4};
        tbl[5] = '{4'hF, 1'b1, 4'h2, 1'b1, 5};
        tbl[6] = '{4'hF, 1'b1, 4'h4, 1'b1, 6};
        tbl[7] = '{4'hF, 1'b1, 4'h8, 1'b1, 7};
        tbl[8] = '{4'hF, 1'b0, 4'h0, 1'b0, 8};
        tbl[9] = '{4'hF, 1'b0, 4'h0, 1'b0, 8};

        reset = 1'b1;
        rr_m = 0;
        drive(4'hF, 1'b1, 1'b1, 32'hDEAD, 4'hF);
        @(posedge clk); #1;
        q.delete();

        // Outputs held low during reset regardless of inputs.
        settle();
        chk("rst_cache_v", c_v_out, 0);
        chk("rst_req_yumi", req_yumi, 0);
        chk("rst_resp_v", resp_v, 0);
        chk("rst_cache_yumi", c_yumi_out, 0);
        chk("rst_outstanding", outstanding, 0);
        commit();
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].rv, tbl[i].cy, 1'b0, 32'h0, 4'hF);
            settle();
            chk("tbl_req_yumi", req_yumi, tbl[i].exp_yumi);
            chk("tbl_cache_v", c_v_out, tbl[i].exp_cv);
            chk("tbl_outstanding", outstanding, tbl[i].exp_out);
            $display("vec %0d: req_yumi=%b cache_v=%b outstanding=%0d", i, req_yumi, c_v_out, outstanding);
            commit();
        end

        // Full: a pop in the same cycle keeps cache_v_o low; next cycle it rises.
        drive(4'hF, 1'b0, 1'b1, 32'h11, 4'hF);
        settle();
        chk("full_pop_cache_v", c_v_out, 0);
        chk("full_pop_yumi", c_yumi_out, 1);
        chk("full_pop_resp_v", resp_v, 4'b0001);
        commit();
        drive(4'hF, 1'b1, 1'b0, 32'h0, 4'hF);
        settle();
        chk("after_pop_cache_v", c_v_out, 1);
        chk("after_pop_outstanding", outstanding, 7);
        commit();
        drain();

        // Round-robin from pointer 2 with channels 1 and 3.
        drive(4'b0010, 1'b1, 1'b0, 32'h0, 4'hF);
        settle(); chk("rr_setup", req_yumi, 4'b0010); commit();
        drive(4'b1010, 1'b1, 1'b0, 32'h0, 4'hF);
        settle(); chk("rr_first", req_yumi, 4'b1000); commit();
        drive(4'b1010, 1'b1, 1'b0, 32'h0, 4'hF);
        settle(); chk("rr_second", req_yumi, 4'b0010); commit();
        drain();

        // In-order routing: ch2, ch0, ch2 get 0xA, 0xB, 0xC.
        drive(4'b0100, 1'b1, 1'b0, 32'h0, 4'hF); settle(); commit();
        drive(4'b0001, 1'b1, 1'b0, 32'h0, 4'hF); settle(); commit();
        drive(4'b0100, 1'b1, 1'b0, 32'h0, 4'hF); settle(); commit();
        drive(4'h0, 1'b0, 1'b1, 32'hA, 4'hF); settle();
        chk("ord_a_v", resp_v, 4'b0100); chk("ord_a_d", resp_data[2*DW +: DW], 32'hA); commit();
        drive(4'h0, 1'b0, 1'b1, 32'hB, 4'hF); settle();
        chk("ord_b_v", resp_v, 4'b0001); chk("ord_b_d", resp_data[0 +: DW], 32'hB); commit();
        drive(4'h0, 1'b0, 1'b1, 32'hC, 4'hF); settle();
        chk("ord_c_v", resp_v, 4'b0100); chk("ord_c_d", resp_data[2*DW +: DW], 32'hC); commit();

        // Head channel 1 stalls for 5 cycles; channel 3 must wait behind it.
        drive(4'b0010, 1'b1, 1'b0, 32'h0, 4'hF); settle(); commit();
        drive(4'b1000, 1'b1, 1'b0, 32'h0, 4'hF); settle(); commit();
        for (int n = 0; n < 5; n++) begin
            drive(4'h0, 1'b0, 1'b1, 32'h55, 4'b1101);
            settle();
            chk("stall_yumi", c_yumi_out, 0);
            chk("stall_resp_v", resp_v, 4'b0010);
            chk("stall_data", resp_data[1*DW +: DW], 32'h55);
            commit();
        end
        drive(4'h0, 1'b0, 1'b1, 32'h55, 4'hF); settle();
        chk("stall_done_yumi", c_yumi_out, 1); chk("stall_done_data", resp_data[1*DW +: DW], 32'h55); commit();
        drive(4'h0, 1'b0, 1'b1, 32'h66, 4'hF); settle();
        chk("stall_next_v", resp_v, 4'b1000); commit();

        // Reset with 3 outstanding requests.
        drive(4'b0001, 1'b1, 1'b0, 32'h0, 4'hF); settle(); commit();
        drive(4'b0010, 1'b1, 1'b0, 32'h0, 4'hF); settle(); commit();
        drive(4'b0100, 1'b1, 1'b0, 32'h0, 4'hF); settle(); commit();
        reset = 1'b1;
        drive(4'hF, 1'b1, 1'b0, 32'h0, 4'hF); settle();
        chk("midrst_cache_v", c_v_out, 0); chk("midrst_yumi", req_yumi, 0); commit();
        reset = 1'b0;
        drive(4'h0, 1'b0, 1'b0, 32'h0, 4'hF); settle();
        chk("postrst_outstanding", outstanding, 0);
        chk("postrst_cache_v", c_v_out, 0);
        chk("postrst_resp_v", resp_v, 0);
        chk("postrst_cache_yumi", c_yumi_out, 0);
        commit();

        // Randomized traffic against the model, with occasional resets.
        for (int n = 0; n < 500; n++) begin
            logic [3:0] rv;
            logic       cy, cv;
            reset = ($urandom_range(0, 59) == 0);
            rv = 4'($urandom);
            cy = (rv != 0) && (q.size() < MO) && ($urandom_range(0, 3) != 0);
            cv = (q.size() > 0) && ($urandom_range(0, 3) != 0);
            drive(rv, cy, cv, $urandom, 4'($urandom) | 4'($urandom));
            settle();
            commit();
        end
        reset = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
